// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrated N-to-1 registered mux.
package mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Ceiling log2, for tools without a usable $clog2 in constant contexts.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational grant picker: first request at or above ptr (wrapping), or lowest request when fixed.
// The lower half of the doubled vector masks requests below ptr, so the first hit in the upper half wraps.
module rr_prio_pick import mux_pkg::*; #(
  parameter int N = 4,
  localparam int SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          fixed,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;

  always_comb begin
    dbl = '0;
    for (int i = 0; i < N; i++) begin
      dbl[i]     = req[i] && (fixed || (i >= int'(ptr)));
      dbl[N + i] = req[i];
    end
  end

  always_comb begin
    logic hit;
    hit     = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!hit && dbl[i]) begin
        hit     = 1'b1;
        gnt_idx = (i >= N) ? SW'(i - N) : SW'(i);
      end
    end
    any = hit;
  end

endmodule

// File: rtl/mux_arb_nxw.sv
// N-channel arbitrated mux into a single output register; 1-cycle latency, full throughput.
// A stalled output word holds all in_ready low; draining and refilling in one cycle leaves no bubble.
module mux_arb_nxw import mux_pkg::*; #(
  parameter int N    = 4,
  parameter int W    = 1,
  parameter int MODE = MODE_RR,
  localparam int SW  = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  logic          accept, take, any;
  logic [SW-1:0] gnt;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  rr_prio_pick #(.N(N)) u_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .fixed   (MODE == MODE_FIXED),
    .gnt_idx (gnt),
    .any     (any)
  );

  always_comb begin
    accept      = !out_valid_q || out_ready;
    take        = accept && any && !rst;
    in_ready    = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (take) begin
      in_ready[gnt] = 1'b1;
      out_valid_d   = 1'b1;
      out_data_d    = in_data[int'(gnt) * W +: W];
      out_sel_d     = gnt;
      // Wrap at N-1 so a non-power-of-2 N never points past the last channel.
      ptr_d         = (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_nxw.sv
// Scoreboard bench: three instances (RR N=4, RR N=3, fixed N=4), all W=8.
module tb_mux_arb_nxw;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  rr_in_valid, rr_in_ready, fx_in_valid, fx_in_ready;
  logic [31:0] rr_in_data, fx_in_data;
  logic        rr_out_valid, rr_out_ready, fx_out_valid, fx_out_ready;
  logic [7:0]  rr_out_data, fx_out_data, n3_out_data;
  logic [1:0]  rr_out_sel, fx_out_sel, n3_out_sel;
  logic [2:0]  n3_in_valid, n3_in_ready;
  logic [23:0] n3_in_data;
  logic        n3_out_valid, n3_out_ready;

  mux_arb_nxw #(.N(4), .W(8), .MODE(0)) u_rr (
    .clk(clk), .rst(rst), .in_valid(rr_in_valid), .in_data(rr_in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_sel(rr_out_sel), .out_ready(rr_out_ready));

  mux_arb_nxw #(.N(3), .W(8), .MODE(0)) u_n3 (
    .clk(clk), .rst(rst), .in_valid(n3_in_valid), .in_data(n3_in_data),
    .in_ready(n3_in_ready), .out_valid(n3_out_valid), .out_data(n3_out_data),
    .out_sel(n3_out_sel), .out_ready(n3_out_ready));

  mux_arb_nxw #(.N(4), .W(8), .MODE(1)) u_fx (
    .clk(clk), .rst(rst), .in_valid(fx_in_valid), .in_data(fx_in_data),
    .in_ready(fx_in_ready), .out_valid(fx_out_valid), .out_data(fx_out_data),
    .out_sel(fx_out_sel), .out_ready(fx_out_ready));

  int total = 0;
  int bad   = 0;
  logic [15:0] q_rr[$], q_n3[$], q_fx[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor_step();
    logic [15:0] e;
    if (!rst && rr_out_valid && rr_out_ready) begin
      if (q_rr.size() == 0) chk("rr_unexpected_word", {22'b0, rr_out_sel, rr_out_data}, 32'hFFFF_FFFF);
      else begin e = q_rr.pop_front(); chk("rr_word", {22'b0, rr_out_sel, rr_out_data}, {16'b0, e}); end
    end
    if (!rst && n3_out_valid && n3_out_ready) begin
      if (q_n3.size() == 0) chk("n3_unexpected_word", {22'b0, n3_out_sel, n3_out_data}, 32'hFFFF_FFFF);
      else begin e = q_n3.pop_front(); chk("n3_word", {22'b0, n3_out_sel, n3_out_data}, {16'b0, e}); end
    end
    if (!rst && fx_out_valid && fx_out_ready) begin
      if (q_fx.size() == 0) chk("fx_unexpected_word", {22'b0, fx_out_sel, fx_out_data}, 32'hFFFF_FFFF);
      else begin e = q_fx.pop_front(); chk("fx_word", {22'b0, fx_out_sel, fx_out_data}, {16'b0, e}); end
    end
  endtask

  initial begin
    logic [2:0] n3_vec [5];
    logic [1:0] n3_sel [5];
    n3_vec = '{3'b001, 3'b101, 3'b101, 3'b100, 3'b111};
    n3_sel = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};

    rst = 1'b1;
    rr_in_valid = 4'hF; rr_in_data = 32'h13121110; rr_out_ready = 1'b1;
    n3_in_valid = '0;   n3_in_data = 24'h222120;   n3_out_ready = 1'b1;
    fx_in_valid = '0;   fx_in_data = 32'h33323130; fx_out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset held two cycles with all requests up.
    step(); step();
    @(negedge clk);
    chk("rst_in_ready", {28'b0, rr_in_ready}, 32'h0);
    chk("rst_out_valid", {31'b0, rr_out_valid}, 32'h0);
    chk("rst_out_data", {24'b0, rr_out_data}, 32'h0);
    chk("rst_out_sel", {30'b0, rr_out_sel}, 32'h0);

    // Round-robin over all four channels, one word per cycle.
    step();
    rst = 1'b0;
    q_rr.push_back({6'b0, 2'd0, 8'h10});
    q_rr.push_back({6'b0, 2'd1, 8'h11});
    q_rr.push_back({6'b0, 2'd2, 8'h12});
    q_rr.push_back({6'b0, 2'd3, 8'h13});
    q_rr.push_back({6'b0, 2'd0, 8'h10});
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("rr_stream_vld", {31'b0, rr_out_valid}, 32'h1);
    end
    rr_in_valid = 4'h0;
    step(); step();
    chk("rr_drained", {31'b0, rr_out_valid}, 32'h0);

    // Backpressure: channel 1's word stalls 3 cycles, then channel 2 follows.
    rr_in_valid = 4'hF; rr_out_ready = 1'b0;
    q_rr.push_back({6'b0, 2'd1, 8'h11});
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_data", {24'b0, rr_out_data}, 32'h11);
      chk("bp_out_valid", {31'b0, rr_out_valid}, 32'h1);
      chk("bp_in_ready", {28'b0, rr_in_ready}, 32'h0);
      step();
    end
    rr_out_ready = 1'b1;
    q_rr.push_back({6'b0, 2'd2, 8'h12});
    @(negedge clk);
    chk("bp_next_grant", {28'b0, rr_in_ready}, 32'h4);
    step();
    rr_in_valid = 4'h0;
    step(); step();

    // N=3 sparse requests with pointer wrap at 2.
    for (int i = 0; i < 5; i++) begin
      n3_in_valid = n3_vec[i];
      q_n3.push_back({6'b0, n3_sel[i], 8'h20 + {6'b0, n3_sel[i]}});
      step();
    end
    n3_in_valid = '0;
    step(); step();

    // Fixed priority: channel 1 always beats channel 3.
    fx_in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      q_fx.push_back({6'b0, 2'd1, 8'h31});
      step();
      @(negedge clk);
      chk("fx_in_ready", {28'b0, fx_in_ready}, 32'h2);
    end
    fx_in_valid = 4'h0;
    step(); step();

    // Reset while a stalled word from channel 2 is held.
    rr_in_valid = 4'b0100; rr_out_ready = 1'b0;
    step();
    @(negedge clk);
    chk("mid_pre_valid", {31'b0, rr_out_valid}, 32'h1);
    chk("mid_pre_sel", {30'b0, rr_out_sel}, 32'h2);
    rst = 1'b1;
    step();
    rst = 1'b0; rr_in_valid = 4'hF; rr_out_ready = 1'b1;
    @(negedge clk);
    chk("mid_post_valid", {31'b0, rr_out_valid}, 32'h0);
    chk("mid_post_grant", {28'b0, rr_in_ready}, 32'h1);
    q_rr.push_back({6'b0, 2'd0, 8'h10});
    step();
    rr_in_valid = 4'h0;
    step(); step();

    for (int i = 0; i < 10 && (q_rr.size() + q_n3.size() + q_fx.size()) != 0; i++) step();
    chk("rr_queue_left", q_rr.size(), 0);
    chk("n3_queue_left", q_n3.size(), 0);
    chk("fx_queue_left", q_fx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
